reg_read_arbiter: RTL and testbench
===================================

# reg_read_arbiter

Read-side companion to the two-writer 32-bit register (`Register2`). It arbitrates read requests from two clients, snapshots the register's output, and returns the value with a 4-phase request/acknowledge handshake. It sits between the register's `OUT` bus and the two datapath consumers that previously tapped that bus directly. Each consumer therefore receives a stable, attributed copy of the register value.

## Interface
- `WIDTH`, default 32: data width; must match the register's width.
- `CNT_W`, default 16: width of the completed-read counter.

Ports:
- `Clk`  in  1  rising-edge clock
- `Reset`  in  1  synchronous, active-high reset
- `REG_IN`  in  `WIDTH`  register output bus being read
- `Req`  in  1  client 1 read request; level, held until `Ack` seen
- `Req2`  in  1  client 2 read request; level, held until `Ack2` seen
- `OUT`  out  `WIDTH`  snapshot data returned to the granted client
- `Ack`  out  1  client 1 acknowledge, 1-cycle pulse
- `Ack2`  out  1  client 2 acknowledge, 1-cycle pulse
- `Busy`  out  1  high whenever the FSM is not in IDLE
- `RdCount`  out  `CNT_W`  number of reads completed, modulo 2^`CNT_W`

## Operation
- The FSM has four states: IDLE, SAMPLE, ACK, WAIT_DROP. All outputs are registered and Moore-style.
- Internal registers:
  - `grant`: 1 = client 1, 2 = client 2.
  - `last`: the client most recently served.
- **IDLE**
  - If only `Req` is high: grant = 1, go to SAMPLE.
  - If only `Req2` is high: grant = 2, go to SAMPLE.
  - If both are high: grant goes to the client that is not `last` (round-robin), go to SAMPLE.
  - If neither is high: stay in IDLE.
- **SAMPLE**
  - `OUT` <= `REG_IN`.
  - Go to ACK.
- **ACK**
  - The granted client's ack is high for exactly this state.
  - On exit: `last` <= grant and `RdCount` increments.
  - If the granted request is already low, go to IDLE; otherwise go to WAIT_DROP.
- **WAIT_DROP**
  - Both acks are low.
  - Stay until the granted request goes low, then go to IDLE.
- **Held data:** `OUT` holds the last snapshot indefinitely. It changes only in SAMPLE and on `Reset`.
- **Pending request:** the non-granted request stays pending and is served on the next return to IDLE. There is no starvation: with both clients continuously requesting, grants alternate.
- **Register changes:** `REG_IN` changes after SAMPLE do not affect `OUT` for the current transaction.
- **Counter wrap:** `RdCount` wraps from 2^`CNT_W`−1 to 0 with no flag.
- **Reset**
  - Reset dominates all other inputs.
  - Reset values: state = IDLE, `OUT` = 0, `Ack` = 0, `Ack2` = 0, `Busy` = 0, `RdCount` = 0, `last` = 2, so client 1 wins the first tie.
  - Reset mid-transaction aborts the transaction: no ack is issued and `RdCount` does not increment. A request still held after reset is restarted from IDLE.

## Timing
Edge numbering is relative to edge k, the first edge at which a request is sampled high in IDLE.

- **Latency:** request sampled at edge k; after edge k+1, `OUT` holds the value of `REG_IN` sampled at edge k+1 and the ack goes high. Request-to-ack is 2 cycles.
- **Busy:** high from after edge k until the return to IDLE.
- **Ack pulse:** exactly 1 cycle, after edge k+1 until edge k+2.
- **Request already dropped:** if the request is low at edge k+2, the FSM is back in IDLE after edge k+2. The next request can be sampled at edge k+3.
- **Request held:** if the request is high at edge k+2, the FSM is in WAIT_DROP and exits to IDLE one edge after the request is seen low.
- **Peak throughput:** one read per 3 cycles.
- **Data validity:** the client must capture `OUT` while its ack is high. `OUT` remains valid until the next SAMPLE, which occurs no sooner than 2 cycles later.

## Test plan
1. **Reset values:** assert `Reset` for 2 cycles while `Req` = `Req2` = 1 → all outputs 0 throughout. After release, client 1 is granted first.
2. **Single read with held request:** `REG_IN` = 0xDEADBEEF, `Req` pulse held until `Ack` →
   - `Ack` goes high 2 cycles after `Req` is sampled, with `OUT` = 0xDEADBEEF.
   - `Ack2` stays 0; `RdCount` = 1.
   - `Busy` drops one edge after `Req` is seen low.
3. **Tie and round-robin:** `Req` = `Req2` = 1 held continuously, each dropped one cycle after its own ack, then re-raised. `REG_IN` increments every cycle →
   - Ack order is 1, 2, 1, 2.
   - Each `OUT` equals the `REG_IN` value sampled in SAMPLE.
   - `RdCount` = 4 after 4 acks.
4. **Snapshot stability:** `REG_IN` changes from 5 to 9 one cycle after the ack → `OUT` stays 5 until the next transaction's SAMPLE.
5. **Reset mid-transaction:** assert `Reset` in SAMPLE →
   - No ack is issued; `OUT` = 0; `RdCount` does not increment.
   - With `Req` still high after reset, the read restarts and acks 2 cycles later.
6. **Counter wrap:** `CNT_W` = 4, 17 completed reads → `RdCount` reads 15 after the 15th read, 0 after the 16th, and 1 after the 17th.

Source files
------------

// File: rtl/reg_read_arbiter.sv
// Two-client read arbiter for a shared register: round-robin grant, snapshot, 4-phase ack.
// Latency: request sampled to ack is 2 cycles; a new request is held off while Busy is high.
module reg_read_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] REG_IN,
  input  logic             Req,
  input  logic             Req2,
  output logic [WIDTH-1:0] OUT,
  output logic             Ack,
  output logic             Ack2,
  output logic             Busy,
  output logic [CNT_W-1:0] RdCount
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SAMPLE    = 2'd1,
    S_ACK       = 2'd2,
    S_WAIT_DROP = 2'd3
  } state_t;

  localparam logic [1:0] CLIENT1 = 2'd1;
  localparam logic [1:0] CLIENT2 = 2'd2;

  state_t           r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_last;
  logic [WIDTH-1:0] r_out;
  logic             r_ack;
  logic             r_ack2;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic             w_gnt_req;
  logic [1:0]       w_pick;

  assign w_gnt_req = (r_grant == CLIENT1) ? Req : Req2;

  // On a tie the client that was not served last wins, so neither can starve.
  always_comb begin
    w_pick = CLIENT1;
    if (Req && Req2) begin
      w_pick = (r_last == CLIENT1) ? CLIENT2 : CLIENT1;
    end else if (Req2) begin
      w_pick = CLIENT2;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_grant <= CLIENT1;
      r_last  <= CLIENT2;
      r_out   <= '0;
      r_ack   <= 1'b0;
      r_ack2  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Req || Req2) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_out   <= REG_IN;
          r_ack   <= (r_grant == CLIENT1);
          r_ack2  <= (r_grant == CLIENT2);
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_ack2  <= 1'b0;
          r_last  <= r_grant;
          r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!w_gnt_req) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT_DROP;
          end
        end
        S_WAIT_DROP: begin
          if (!w_gnt_req) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_ack2  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign OUT     = r_out;
  assign Ack     = r_ack;
  assign Ack2    = r_ack2;
  assign Busy    = r_busy;
  assign RdCount = r_cnt;

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_reg_read_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] REG_IN;
  logic        Req;
  logic        Req2;
  logic [31:0] OUT;
  logic        Ack;
  logic        Ack2;
  logic        Busy;
  logic [15:0] RdCount;

  logic [31:0] w_out;
  logic        w_ack;
  logic        w_ack2;
  logic        w_busy;
  logic [3:0]  w_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  reg_read_arbiter #(.WIDTH(32), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .REG_IN(REG_IN), .Req(Req), .Req2(Req2),
    .OUT(OUT), .Ack(Ack), .Ack2(Ack2), .Busy(Busy), .RdCount(RdCount)
  );

  reg_read_arbiter #(.WIDTH(32), .CNT_W(4)) u_wrap (
    .Clk(Clk), .Reset(Reset), .REG_IN(REG_IN), .Req(Req), .Req2(Req2),
    .OUT(w_out), .Ack(w_ack), .Ack2(w_ack2), .Busy(w_busy), .RdCount(w_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Req   = 1'b0;
    Req2  = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  int          d1, d2, n;
  int          exp_who [4] = '{1, 2, 1, 2};
  logic [31:0] exp_out [4] = '{32'h101, 32'h105, 32'h109, 32'h10D};
  int          exp_cyc [4] = '{2, 6, 10, 14};

  initial begin
    Reset = 1'b1; Req = 1'b1; Req2 = 1'b1; REG_IN = 32'h0;

    // reset held with both requests high
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("rst_out",   OUT, 0);
      check("rst_ack",   Ack, 0);
      check("rst_ack2",  Ack2, 0);
      check("rst_busy",  Busy, 0);
      check("rst_count", RdCount, 0);
    end
    Reset = 1'b0; REG_IN = 32'h11;
    @(negedge Clk);
    check("first_busy", Busy, 1);
    check("first_ack_early", Ack, 0);
    @(negedge Clk);
    check("first_ack", Ack, 1);
    check("first_ack2", Ack2, 0);
    check("first_out", OUT, 32'h11);
    Req = 1'b0; Req2 = 1'b0;
    @(negedge Clk);
    check("first_idle", Busy, 0);
    check("first_count", RdCount, 1);

    // single read, request held past the ack
    do_reset();
    REG_IN = 32'hDEADBEEF; Req = 1'b1;
    @(negedge Clk);
    check("single_busy", Busy, 1);
    check("single_ack_early", Ack, 0);
    @(negedge Clk);
    check("single_ack", Ack, 1);
    check("single_ack2", Ack2, 0);
    check("single_out", OUT, 32'hDEADBEEF);
    @(negedge Clk);
    check("single_ack_pulse", Ack, 0);
    check("single_wait_busy", Busy, 1);
    check("single_count", RdCount, 1);
    Req = 1'b0;
    @(negedge Clk);
    check("single_drop_busy", Busy, 0);
    check("single_ack2_quiet", Ack2, 0);

    // tie with round-robin, REG_IN changing every cycle
    do_reset();
    d1 = -5; d2 = -5; n = 0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge Clk);
      if (c > 0 && (Ack || Ack2)) begin
        if (n < 4) begin
          check("rr_who", Ack2 ? 2 : 1, exp_who[n]);
          check("rr_out", OUT, exp_out[n]);
          check("rr_cyc", c, exp_cyc[n]);
          n++;
        end else begin
          check("rr_extra_ack", n, 4);
        end
        if (Ack)  d1 = c + 1;
        if (Ack2) d2 = c + 1;
      end
      REG_IN = 32'h100 + c;
      if (c == 0) begin
        Req = 1'b1; Req2 = 1'b1;
      end else if (c >= 15) begin
        Req = 1'b0; Req2 = 1'b0;
      end else begin
        if (c == d1) Req = 1'b0; else if (c == d1 + 1) Req = 1'b1;
        if (c == d2) Req2 = 1'b0; else if (c == d2 + 1) Req2 = 1'b1;
      end
    end
    check("rr_acks", n, 4);
    check("rr_count", RdCount, 4);
    check("rr_idle", Busy, 0);

    // snapshot stays put while REG_IN moves on
    REG_IN = 32'd5; Req = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("snap_ack", Ack, 1);
    check("snap_out", OUT, 5);
    Req = 1'b0;
    @(negedge Clk);
    REG_IN = 32'd9;
    check("snap_hold0", OUT, 5);
    @(negedge Clk);
    check("snap_hold1", OUT, 5);
    Req2 = 1'b1;
    @(negedge Clk);
    check("snap_pre_sample", OUT, 5);
    @(negedge Clk);
    check("snap_ack2", Ack2, 1);
    check("snap_new_out", OUT, 9);
    Req2 = 1'b0;
    @(negedge Clk);

    // reset asserted while in SAMPLE
    do_reset();
    REG_IN = 32'h77; Req = 1'b1;
    @(negedge Clk);
    check("abort_busy", Busy, 1);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_ack", Ack, 0);
    check("abort_out", OUT, 0);
    check("abort_count", RdCount, 0);
    check("abort_busy_clr", Busy, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("restart_ack_early", Ack, 0);
    @(negedge Clk);
    check("restart_ack", Ack, 1);
    check("restart_out", OUT, 32'h77);
    Req = 1'b0;
    @(negedge Clk);
    check("restart_count", RdCount, 1);

    // 17 reads through the 4-bit counter instance
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      @(negedge Clk);
      REG_IN = i; Req = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      check("wrap_ack", w_ack, 1);
      Req = 1'b0;
      @(negedge Clk);
      if (i == 15) check("wrap_15", w_cnt, 15);
      if (i == 16) check("wrap_16", w_cnt, 0);
      if (i == 17) check("wrap_17", w_cnt, 1);
    end
    check("wrap_wide_count", RdCount, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
